// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller and the datapath.
// The controller holds the slave modport; the datapath (or a bench) holds master.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       stall;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       half;
  logic       half_unsigned;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output opcode, stall,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, half, half_unsigned, illegal_op, state
  );

  modport slave (
    input  opcode, stall,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, half, half_unsigned, illegal_op, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// with configurable memory wait states, optional halfword loads, stall and illegal-opcode detect.
module mc_control_fsm #(
  parameter int MEM_WAIT = 0,
  parameter bit HALF_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mc_control_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam int              CW       = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0]   WAIT_MAX = CW'(MEM_WAIT);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic          decode_illegal;
  logic          last_wait;

  assign last_wait = (cnt_q == WAIT_MAX);

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    decode_illegal = 1'b0;

    if (!bus.stall) begin
      case (state_q)
        S_FETCH: begin
          if (last_wait) state_d = S_DECODE;
          else           cnt_d   = cnt_q + CNT_ONE;
        end
        S_DECODE: begin
          op_d = bus.opcode;
          case (bus.opcode)
            OP_RTYPE:      state_d = S_EXEC_R;
            OP_ADDI:       state_d = S_EXEC_I;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_LH, OP_LHU: begin
              if (HALF_EN) begin
                state_d = S_MEM_ADDR;
              end else begin
                state_d        = S_FETCH;
                decode_illegal = 1'b1;
              end
            end
            OP_BEQ:        state_d = S_BRANCH;
            OP_J:          state_d = S_JUMP;
            default: begin
              state_d        = S_FETCH;
              decode_illegal = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (last_wait) state_d = S_MEM_WB;
          else           cnt_d   = cnt_q + CNT_ONE;
        end
        S_MEM_WR: begin
          if (last_wait) state_d = S_FETCH;
          else           cnt_d   = cnt_q + CNT_ONE;
        end
        S_EXEC_R: state_d = S_R_WB;
        S_EXEC_I: state_d = S_I_WB;
        default:  state_d = S_FETCH;
      endcase

      // Each memory phase starts counting from zero; the count stops at WAIT_MAX.
      if (state_d != state_q) cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Write enables are blanked during stall; reads and mux selects keep their state values.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.half          = 1'b0;
    bus.half_unsigned = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.state         = 4'd0;

    if (!reset) begin
      bus.state      = state_q;
      bus.illegal_op = decode_illegal;
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = last_wait && !bus.stall;
          bus.pc_write  = last_wait && !bus.stall;
        end
        S_DECODE:   bus.alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write     = !bus.stall;
          bus.mem_to_reg    = 1'b1;
          bus.half          = HALF_EN && ((op_q == OP_LH) || (op_q == OP_LHU));
          bus.half_unsigned = HALF_EN && (op_q == OP_LHU);
        end
        S_MEM_WR: begin
          bus.mem_write = !bus.stall;
          bus.i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_R_WB: begin
          bus.reg_write = !bus.stall;
          bus.reg_dst   = 1'b1;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_I_WB:     bus.reg_write = !bus.stall;
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = !bus.stall;
          bus.pc_source     = 2'b01;
        end
        S_JUMP: begin
          bus.pc_write  = !bus.stall;
          bus.pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: three instances cover MEM_WAIT=0, MEM_WAIT=2 and HALF_EN=0.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic [5:0] opcode = 6'b000000;

  always #5 clk = ~clk;

  mc_control_fsm_if b0 ();
  mc_control_fsm_if b2 ();
  mc_control_fsm_if bn ();

  assign b0.opcode = opcode;
  assign b0.stall  = stall;
  assign b2.opcode = opcode;
  assign b2.stall  = stall;
  assign bn.opcode = opcode;
  assign bn.stall  = stall;

  mc_control_fsm #(.MEM_WAIT(0), .HALF_EN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  mc_control_fsm #(.MEM_WAIT(2), .HALF_EN(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  mc_control_fsm #(.MEM_WAIT(0), .HALF_EN(1'b0)) dutn (.clk(clk), .reset(reset), .bus(bn));

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rw, rdst, asa;
    logic [1:0] asb, aop, psrc;
    logic       half, hu, ill;
  } snap_t;

  typedef struct packed {
    logic       rst;
    logic       stl;
    logic [5:0] op;
    logic [3:0] st;
    logic       last;
    logic       he;
  } stim_t;

  snap_t s0, s2, sn;
  assign s0 = {b0.state, b0.pc_write, b0.pc_write_cond, b0.i_or_d, b0.mem_read, b0.mem_write,
               b0.ir_write, b0.mem_to_reg, b0.reg_write, b0.reg_dst, b0.alu_src_a, b0.alu_src_b,
               b0.alu_op, b0.pc_source, b0.half, b0.half_unsigned, b0.illegal_op};
  assign s2 = {b2.state, b2.pc_write, b2.pc_write_cond, b2.i_or_d, b2.mem_read, b2.mem_write,
               b2.ir_write, b2.mem_to_reg, b2.reg_write, b2.reg_dst, b2.alu_src_a, b2.alu_src_b,
               b2.alu_op, b2.pc_source, b2.half, b2.half_unsigned, b2.illegal_op};
  assign sn = {bn.state, bn.pc_write, bn.pc_write_cond, bn.i_or_d, bn.mem_read, bn.mem_write,
               bn.ir_write, bn.mem_to_reg, bn.reg_write, bn.reg_dst, bn.alu_src_a, bn.alu_src_b,
               bn.alu_op, bn.pc_source, bn.half, bn.half_unsigned, bn.illegal_op};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  stim_t stim_q[$];
  snap_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic illegal_code(input logic [5:0] op, input logic he);
    case (op)
      RT, ADDI, LW, SW, BEQ, JMP: return 1'b0;
      LH, LHU:                    return !he;
      default:                    return 1'b1;
    endcase
  endfunction

  // Reference output table, written directly from the controller's state/output list.
  function automatic snap_t exp_snap(input stim_t s);
    snap_t e;
    e = '0;
    if (s.rst) return e;
    e.st = s.st;
    case (s.st)
      4'd0:  begin e.mr = 1'b1; e.asb = 2'b01; e.irw = s.last & !s.stl; e.pcw = s.last & !s.stl; end
      4'd1:  begin e.asb = 2'b11; e.ill = illegal_code(s.op, s.he) & !s.stl; end
      4'd2:  begin e.asa = 1'b1; e.asb = 2'b10; end
      4'd3:  begin e.mr = 1'b1; e.iord = 1'b1; end
      4'd4:  begin
               e.rw = !s.stl; e.m2r = 1'b1;
               e.half = s.he & ((s.op == LH) | (s.op == LHU));
               e.hu   = s.he & (s.op == LHU);
             end
      4'd5:  begin e.mw = !s.stl; e.iord = 1'b1; end
      4'd6:  begin e.asa = 1'b1; e.aop = 2'b10; end
      4'd7:  begin e.rw = !s.stl; e.rdst = 1'b1; end
      4'd8:  begin e.asa = 1'b1; e.asb = 2'b10; end
      4'd9:  e.rw = !s.stl;
      4'd10: begin e.asa = 1'b1; e.aop = 2'b01; e.pcwc = !s.stl; e.psrc = 2'b01; end
      4'd11: begin e.pcw = !s.stl; e.psrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic add_rst(input logic [5:0] op);
    stim_q.push_back('{rst: 1'b1, stl: 1'b0, op: op, st: 4'd0, last: 1'b0, he: 1'b1});
  endtask

  // Memory states (0,3,5) expand to w+1 cycles unless stalled.
  task automatic add(input logic [3:0] st, input logic [5:0] op, input int w, input logic he,
                     input logic stl = 1'b0);
    int n;
    n = ((st == 4'd0 || st == 4'd3 || st == 4'd5) && !stl) ? w + 1 : 1;
    for (int i = 0; i < n; i++)
      stim_q.push_back('{rst: 1'b0, stl: stl, op: op, st: st, last: (i == n - 1) && !stl, he: he});
  endtask

  task automatic add_path(input logic [5:0] op, input int w, input logic he, input int path[$]);
    foreach (path[i]) add(4'(path[i]), op, w, he);
  endtask

  task automatic run(input int sel, input string name);
    stim_t s;
    snap_t got, e;
    int    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(negedge clk);
      reset  = s.rst;
      stall  = s.stl;
      opcode = s.op;
      sb_q.push_back(exp_snap(s));
      #1;
      got = (sel == 0) ? s0 : (sel == 2) ? s2 : sn;
      e   = sb_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL %s cycle %0d: got %06h (state %0d) expected %06h (state %0d)",
                 name, cyc, got, got.st, e, e.st);
      else
        n_pass++;
      cyc++;
    end
  endtask

  // Cycles from first FETCH cycle until the DUT re-enters FETCH.
  task automatic check_latency(input int sel, input logic [5:0] op, input int exp_lat,
                               input string name);
    logic [3:0] st;
    bit         seen = 1'b0;
    bit         done = 1'b0;
    int         lat  = 0;
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; opcode = op;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      st = (sel == 0) ? s0.st : (sel == 2) ? s2.st : sn.st;
      if (seen && st == 4'd0) done = 1'b1;
      else begin
        if (st != 4'd0) seen = 1'b1;
        lat++;
      end
    end
    n_checks++;
    if (!done)            $display("FAIL %s latency: no return to FETCH within 60 cycles", name);
    else if (lat != exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    else                  n_pass++;
  endtask

  task automatic test_reset();
    add_rst(LW);
    add_rst(LW);
    add(4'd0, LW, 0, 1'b1);
    run(0, "reset");
  endtask

  task automatic test_lw();
    add_rst(LW);
    add_path(LW, 0, 1'b1, '{0, 1, 2, 3, 4, 0});
    run(0, "lw");
    check_latency(0, LW, 5, "lw_w0");
  endtask

  task automatic test_half_wait();
    add_rst(LHU);
    add_path(LHU, 2, 1'b1, '{0, 1, 2, 3, 4, 0});
    run(2, "lhu_w2");
    check_latency(2, LHU, 9, "lhu_w2");
    add_rst(LH);
    add_path(LH, 0, 1'b1, '{0, 1, 2, 3, 4, 0});
    run(0, "lh_w0");
  endtask

  task automatic test_latency_w2();
    check_latency(2, SW, 8, "sw_w2");
    check_latency(2, RT, 6, "rtype_w2");
    check_latency(2, ADDI, 6, "addi_w2");
    check_latency(2, BEQ, 5, "beq_w2");
    check_latency(2, JMP, 5, "j_w2");
  endtask

  task automatic test_illegal();
    add_rst(LH);
    add_path(LH, 0, 1'b0, '{0, 1, 0, 1, 0});
    run(1, "lh_half_dis");
    add_rst(BAD);
    add(4'd0, BAD, 0, 1'b1);
    add(4'd1, BAD, 0, 1'b1, 1'b1);
    add_path(BAD, 0, 1'b1, '{1, 0});
    run(0, "illegal_stall_decode");
  endtask

  task automatic test_stall_sw();
    add_rst(SW);
    add_path(SW, 0, 1'b1, '{0, 1, 2});
    add(4'd5, SW, 0, 1'b1, 1'b1);
    add(4'd5, SW, 0, 1'b1, 1'b1);
    add_path(SW, 0, 1'b1, '{5, 0});
    run(0, "sw_stall");
  endtask

  task automatic test_back_to_back();
    add_rst(BEQ);
    add_path(BEQ, 0, 1'b1, '{0, 1, 10});
    add_path(JMP, 0, 1'b1, '{0, 1, 11});
    add_path(RT, 0, 1'b1, '{0, 1, 6, 7});
    add_path(ADDI, 0, 1'b1, '{0, 1, 8, 9, 0});
    run(0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    add_rst(RT);
    add_path(RT, 0, 1'b1, '{0, 1, 6});
    add_rst(RT);
    add(4'd0, RT, 0, 1'b1);
    run(0, "reset_in_exec_r");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_half_wait();
    test_latency_w2();
    test_illegal();
    test_stall_sw();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main controller; successor to the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and muxes.
- Supports configurable memory wait states and optional halfword loads (lh/lhu).
- Adds a stall input and illegal-opcode detection.
- Sits between the instruction register opcode field and the multicycle datapath.

Parameters:
- MEM_WAIT, 0, extra wait cycles per memory access (fetch, load, store); each memory state lasts MEM_WAIT+1 cycles.
- HALF_EN, 1, 1 = lh (100001) and lhu (100101) legal; 0 = both decoded as illegal.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from IR; sampled only in DECODE.
- stall  in  1  freeze FSM and wait counter.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write if ALU zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read.
- mem_write  out  1  memory write.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register writeback source: 1 = MDR.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- half  out  1  halfword load in writeback.
- half_unsigned  out  1  zero-extend halfword.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset: synchronous, active-high. On the edge with reset=1: state <= FETCH(0), wait counter <= 0, latched opcode op_q <= 0. While reset=1, all outputs are 0. The first cycle after deassertion is FETCH with the counter at 0.
- Reset mid-instruction: the instruction is abandoned; no write enables assert in the reset cycle.
- Output decode:
  - Outputs are combinational from state, counter, op_q and stall.
  - Every signal not listed for a state is 0.
- State encodings and outputs:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=1 and pc_write=1 only on the final wait cycle (counter==MEM_WAIT).
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Latch op_q <= opcode.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_RD(3): mem_read=1, i_or_d=1 for MEM_WAIT+1 cycles.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0.
    - half=1 when op_q is lh or lhu; half_unsigned=1 when op_q is lhu.
    - half and half_unsigned are 0 in every other state.
  - MEM_WR(5): mem_write=1, i_or_d=1 for MEM_WAIT+1 cycles.
  - EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0.
  - EXEC_I(8): alu_src_a=1, alu_src_b=10, alu_op=00.
  - I_WB(9): reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP(11): pc_write=1, pc_source=10.
- Transitions:
  - FETCH -> DECODE when counter==MEM_WAIT; otherwise stay and increment the counter.
  - DECODE dispatches on opcode:
    - 000000 -> EXEC_R
    - 001000 -> EXEC_I
    - 100011, 101011, 100001, 100101 -> MEM_ADDR (lh/lhu only if HALF_EN=1)
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - any other opcode -> FETCH with illegal_op=1 for that DECODE cycle; no writes occur.
  - MEM_ADDR -> MEM_WR if op_q is 101011, else MEM_RD.
  - MEM_RD -> MEM_WB and MEM_WR -> FETCH, each when counter==MEM_WAIT.
  - EXEC_R -> R_WB; EXEC_I -> I_WB.
  - MEM_WB, R_WB, I_WB, BRANCH, JUMP -> FETCH.
- Wait counter:
  - Width max(1, clog2(MEM_WAIT+1)).
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; never wraps.
- Latency with MEM_WAIT=W (cycles per instruction):
  - lw/lh/lhu: 5+2W
  - sw: 4+2W
  - R-type and addi: 4+W
  - beq and j: 3+W
- Stall:
  - When stall=1, state, counter and op_q hold.
  - pc_write, pc_write_cond, ir_write, reg_write and mem_write are forced 0.
  - mem_read, i_or_d and the mux selects keep their state values.
  - illegal_op is suppressed, and DECODE does not dispatch until stall=0.
  - reset has priority over stall.

Test Plan:
- reset=1 for 2 cycles, then release with MEM_WAIT=0 -> all outputs 0 during reset; cycle 1 shows state=0, mem_read=1, ir_write=1, pc_write=1.
- lw (opcode 100011), MEM_WAIT=0 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; total 5 cycles.
- lhu (100101) with MEM_WAIT=2 -> FETCH 3 cycles with ir_write only on the 3rd; MEM_RD 3 cycles; MEM_WB shows half=1 and half_unsigned=1; total 9 cycles.
- Same lh opcode with HALF_EN=0 -> illegal_op=1 for one cycle in DECODE, return to FETCH, no reg_write or mem_write.
- sw (101011), stall=1 asserted for 2 cycles in MEM_WR -> mem_write=0 during stall, state held at 5, mem_write=1 for 1 cycle after release, then FETCH.
- beq, j and R-type (000000) back to back -> state sequences 0,1,10 / 0,1,11 / 0,1,6,7; pc_write_cond=1 with pc_source=01 in state 10; pc_source=10 in state 11; alu_op=10 in state 6.
- reset asserted in EXEC_R -> next cycle state=0, R_WB never entered, reg_write stays 0.
